// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//   Direct-mapped, write-back, write-allocate cache sitting in front of an
//   8x4 synchronous memory whose data_out is registered (one-edge latency).
//   Four lines of one word each; index = address[1:0], tag = address[2].
//   Every processor access ends with a one-cycle cpu_done pulse.
//
// Ports
//   clock         single clock, all state changes on posedge
//   reset         synchronous, active-low reset
//   cpu_req       request strobe, sampled only while idle
//   cpu_write     1 = write, 0 = read (latched with the request)
//   cpu_address   word address (latched with the request)
//   cpu_data_in   write data (latched with the request)
//   cpu_data_out  read result, held until the next read completes
//   cpu_done      one-cycle completion pulse
//   cpu_hit       access hit flag, meaningful while cpu_done = 1
//   cpu_busy      high in every state except idle
//   mem_write     memory write strobe (only during a writeback)
//   mem_address   memory word address
//   mem_data_out  write data to the memory
//   mem_data_in   registered read data from the memory
// -----------------------------------------------------------------------------
module cache_controller #(
   parameter int ADDRESS_WIDTH = 3,
   parameter int DATA_WIDTH    = 4,
   parameter int INDEX_WIDTH   = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cpu_req,
   input  logic                     cpu_write,
   input  logic [ADDRESS_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0]    cpu_data_in,
   output logic [DATA_WIDTH-1:0]    cpu_data_out,
   output logic                     cpu_done,
   output logic                     cpu_hit,
   output logic                     cpu_busy,
   output logic                     mem_write,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_data_out,
   input  logic [DATA_WIDTH-1:0]    mem_data_in
);

   localparam int LINES     = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WRITEBACK = 3'd2,
      S_FETCH     = 3'd3,
      S_FILL      = 3'd4
   } state_t;

   state_t                                 state_q, state_d;

   // Latched request
   logic                                   req_write_q, req_write_d;
   logic [ADDRESS_WIDTH-1:0]               req_addr_q, req_addr_d;
   logic [DATA_WIDTH-1:0]                  req_data_q, req_data_d;

   // Line storage
   logic [LINES-1:0]                       valid_q, valid_d;
   logic [LINES-1:0]                       dirty_q, dirty_d;
   logic [LINES-1:0][TAG_WIDTH-1:0]        tag_q, tag_d;
   logic [LINES-1:0][DATA_WIDTH-1:0]       line_q, line_d;

   // Registered outputs
   logic [DATA_WIDTH-1:0]                  cpu_data_out_q, cpu_data_out_d;
   logic                                   cpu_done_q, cpu_done_d;
   logic                                   cpu_hit_q, cpu_hit_d;
   logic                                   cpu_busy_q, cpu_busy_d;
   logic                                   mem_write_q, mem_write_d;
   logic [ADDRESS_WIDTH-1:0]               mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0]                  mem_data_out_q, mem_data_out_d;

   // Decoded view of the latched address
   logic [INDEX_WIDTH-1:0]                 idx_s;
   logic [TAG_WIDTH-1:0]                   tag_s;
   logic                                   hit_s;

   // Split the latched address and evaluate the lookup for its line.
   always_comb begin
      idx_s = req_addr_q[INDEX_WIDTH-1:0];
      tag_s = req_addr_q[ADDRESS_WIDTH-1:INDEX_WIDTH];
      hit_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
   end

   // Next-state, line update and output computation for the controller FSM.
   always_comb begin
      state_d        = state_q;
      req_write_d    = req_write_q;
      req_addr_d     = req_addr_q;
      req_data_d     = req_data_q;
      valid_d        = valid_q;
      dirty_d        = dirty_q;
      tag_d          = tag_q;
      line_d         = line_q;
      cpu_data_out_d = cpu_data_out_q;
      cpu_done_d     = 1'b0;
      cpu_hit_d      = cpu_hit_q;
      mem_write_d    = 1'b0;
      mem_address_d  = mem_address_q;
      mem_data_out_d = mem_data_out_q;

      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               req_write_d = cpu_write;
               req_addr_d  = cpu_address;
               req_data_d  = cpu_data_in;
               state_d     = S_LOOKUP;
            end else begin
               state_d     = S_IDLE;
            end
         end

         S_LOOKUP: begin
            if (hit_s) begin
               if (req_write_q) begin
                  line_d[idx_s]  = req_data_q;
                  dirty_d[idx_s] = 1'b1;
               end else begin
                  cpu_data_out_d = line_q[idx_s];
               end
               cpu_done_d = 1'b1;
               cpu_hit_d  = 1'b1;
               state_d    = S_IDLE;
            end else if (valid_q[idx_s] && dirty_q[idx_s]) begin
               // Victim must reach memory before its slot is refilled.
               mem_write_d    = 1'b1;
               mem_address_d  = {tag_q[idx_s], idx_s};
               mem_data_out_d = line_q[idx_s];
               state_d        = S_WRITEBACK;
            end else begin
               mem_address_d  = req_addr_q;
               state_d        = S_FETCH;
            end
         end

         S_WRITEBACK: begin
            // Memory commits the victim on the edge leaving this state.
            mem_address_d = req_addr_q;
            state_d       = S_FETCH;
         end

         S_FETCH: begin
            // Memory samples the read address on the edge leaving this state.
            state_d = S_FILL;
         end

         S_FILL: begin
            valid_d[idx_s] = 1'b1;
            tag_d[idx_s]   = tag_s;
            if (req_write_q) begin
               // Write-allocate: the fetched word is overwritten immediately.
               line_d[idx_s]  = req_data_q;
               dirty_d[idx_s] = 1'b1;
            end else begin
               line_d[idx_s]  = mem_data_in;
               dirty_d[idx_s] = 1'b0;
               cpu_data_out_d = mem_data_in;
            end
            cpu_done_d = 1'b1;
            cpu_hit_d  = 1'b0;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Busy mirrors the state being entered so it is registered alongside it.
      cpu_busy_d = (state_d != S_IDLE);
   end

   // State, line storage and registered outputs with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         req_write_q    <= 1'b0;
         req_addr_q     <= '0;
         req_data_q     <= '0;
         valid_q        <= '0;
         dirty_q        <= '0;
         tag_q          <= '0;
         line_q         <= '0;
         cpu_data_out_q <= '0;
         cpu_done_q     <= 1'b0;
         cpu_hit_q      <= 1'b0;
         cpu_busy_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_address_q  <= '0;
         mem_data_out_q <= '0;
      end else begin
         state_q        <= state_d;
         req_write_q    <= req_write_d;
         req_addr_q     <= req_addr_d;
         req_data_q     <= req_data_d;
         valid_q        <= valid_d;
         dirty_q        <= dirty_d;
         tag_q          <= tag_d;
         line_q         <= line_d;
         cpu_data_out_q <= cpu_data_out_d;
         cpu_done_q     <= cpu_done_d;
         cpu_hit_q      <= cpu_hit_d;
         cpu_busy_q     <= cpu_busy_d;
         mem_write_q    <= mem_write_d;
         mem_address_q  <= mem_address_d;
         mem_data_out_q <= mem_data_out_d;
      end
   end

   assign cpu_data_out = cpu_data_out_q;
   assign cpu_done     = cpu_done_q;
   assign cpu_hit      = cpu_hit_q;
   assign cpu_busy     = cpu_busy_q;
   assign mem_write    = mem_write_q;
   assign mem_address  = mem_address_q;
   assign mem_data_out = mem_data_out_q;

endmodule
